// File: rtl/adc_scan_ctrl_if.sv
// Request/response bundle between the scan controller and the ADC I2C wrapper.
// master = scheduler driving requests; slave = wrapper returning data and ready.
interface adc_scan_ctrl_if;
    logic       wr_req;
    logic       rd_req;
    logic [6:0] device_id;
    logic [7:0] reg_addr;
    logic       reg_addr_vld;
    logic [7:0] wr_data;
    logic       wr_data_vld;
    logic [7:0] rd_data;
    logic       rd_data_vld;
    logic       ready;

    modport master (
        output wr_req, rd_req, device_id, reg_addr, reg_addr_vld, wr_data, wr_data_vld,
        input  rd_data, rd_data_vld, ready
    );

    modport slave (
        input  wr_req, rd_req, device_id, reg_addr, reg_addr_vld, wr_data, wr_data_vld,
        output rd_data, rd_data_vld, ready
    );
endinterface

// File: rtl/adc_scan_ctrl.sv
// Round-robin ADC scanner: per channel a control-byte write then a read; requests are registered
// (one cycle after ready is seen), wait on wrapper ready, and a stalled channel is skipped on timeout.
module adc_scan_ctrl #(
    parameter logic [6:0] DEV_ID     = 7'h48,
    parameter int         NUM_CH     = 4,
    parameter int         SCAN_DIV   = 50_000,
    parameter logic [7:0] CTRL_BASE  = 8'h40,
    parameter int         RD_VLD_CNT = 2,
    parameter int         TIMEOUT    = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_mask,
    adc_scan_ctrl_if.master   adc,
    output logic [7:0]        sample_data,
    output logic [1:0]        sample_ch,
    output logic              sample_vld,
    output logic              busy,
    output logic              err
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int VLD_W = $clog2(RD_VLD_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [VLD_W-1:0] VLD_ALL  = VLD_W'(RD_VLD_CNT);
    localparam logic [VLD_W-1:0] VLD_LAST = VLD_W'(RD_VLD_CNT - 1);
    localparam logic [1:0]       CH_LAST  = 2'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FIND, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE, S_RD_WAIT, S_NEXT
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             seen_low_q, seen_low_d;
    logic [VLD_W-1:0] vld_cnt_q, vld_cnt_d;
    logic             wr_req_q, wr_req_d;
    logic             rd_req_q, rd_req_d;
    logic [7:0]       reg_addr_q, reg_addr_d;
    logic             addr_vld_q, addr_vld_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             wr_data_vld_q, wr_data_vld_d;
    logic [7:0]       sample_data_q, sample_data_d;
    logic [1:0]       sample_ch_q, sample_ch_d;
    logic             sample_vld_q, sample_vld_d;
    logic             err_q, err_d;

    logic       tick;
    logic       in_xact;
    logic       tmo_hit;
    logic       xact_done;
    logic [7:0] ctrl_byte;

    assign tick      = en && (div_q == DIV_LAST);
    assign in_xact   = (state_q == S_WR_ISSUE) || (state_q == S_WR_WAIT) ||
                       (state_q == S_RD_ISSUE) || (state_q == S_RD_WAIT);
    assign tmo_hit   = in_xact && (tmo_q == TMO_LAST);
    // Completion is a low-to-high transition of ready after the request was accepted.
    assign xact_done = seen_low_q && adc.ready;
    assign ctrl_byte = CTRL_BASE | {6'd0, ch_q};

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        div_d         = '0;
        tmo_d         = '0;
        seen_low_d    = 1'b0;
        vld_cnt_d     = vld_cnt_q;
        wr_req_d      = 1'b0;
        rd_req_d      = 1'b0;
        reg_addr_d    = '0;
        addr_vld_d    = 1'b0;
        wr_data_d     = '0;
        wr_data_vld_d = 1'b0;
        sample_data_d = sample_data_q;
        sample_ch_d   = sample_ch_q;
        sample_vld_d  = 1'b0;
        err_d         = 1'b0;

        if (en && (div_q != DIV_LAST)) begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (tick && (|ch_mask)) begin
                    ch_d    = '0;
                    state_d = S_FIND;
                end
            end
            S_FIND: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (ch_mask[ch_q]) begin
                    state_d = S_WR_ISSUE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WR_ISSUE: begin
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else if (adc.ready) begin
                    wr_req_d      = 1'b1;
                    addr_vld_d    = 1'b1;
                    wr_data_vld_d = 1'b1;
                    reg_addr_d    = ctrl_byte;
                    wr_data_d     = ctrl_byte;
                    state_d       = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (xact_done) begin
                    state_d = S_RD_ISSUE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_RD_ISSUE: begin
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else if (adc.ready) begin
                    rd_req_d   = 1'b1;
                    addr_vld_d = 1'b1;
                    reg_addr_d = ctrl_byte;
                    state_d    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Count strobes up to RD_VLD_CNT; the last one carries the sample, extras are dropped.
                if (adc.rd_data_vld && (vld_cnt_q != VLD_ALL)) begin
                    vld_cnt_d = vld_cnt_q + VLD_W'(1);
                    if (vld_cnt_q == VLD_LAST) begin
                        sample_data_d = adc.rd_data;
                        sample_ch_d   = ch_q;
                        sample_vld_d  = 1'b1;
                    end
                end
                if (xact_done && (vld_cnt_d == VLD_ALL)) begin
                    state_d = S_NEXT;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!en || (ch_q == CH_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    state_d = S_FIND;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Per-state bookkeeping restarts on every state change.
        if (state_d != state_q) begin
            vld_cnt_d = '0;
        end else begin
            if (in_xact) begin
                tmo_d = tmo_q + TMO_W'(1);
            end
            seen_low_d = seen_low_q || !adc.ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            div_q         <= '0;
            tmo_q         <= '0;
            seen_low_q    <= 1'b0;
            vld_cnt_q     <= '0;
            wr_req_q      <= 1'b0;
            rd_req_q      <= 1'b0;
            reg_addr_q    <= '0;
            addr_vld_q    <= 1'b0;
            wr_data_q     <= '0;
            wr_data_vld_q <= 1'b0;
            sample_data_q <= '0;
            sample_ch_q   <= '0;
            sample_vld_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            div_q         <= div_d;
            tmo_q         <= tmo_d;
            seen_low_q    <= seen_low_d;
            vld_cnt_q     <= vld_cnt_d;
            wr_req_q      <= wr_req_d;
            rd_req_q      <= rd_req_d;
            reg_addr_q    <= reg_addr_d;
            addr_vld_q    <= addr_vld_d;
            wr_data_q     <= wr_data_d;
            wr_data_vld_q <= wr_data_vld_d;
            sample_data_q <= sample_data_d;
            sample_ch_q   <= sample_ch_d;
            sample_vld_q  <= sample_vld_d;
            err_q         <= err_d;
        end
    end

    assign adc.wr_req       = wr_req_q;
    assign adc.rd_req       = rd_req_q;
    assign adc.device_id    = DEV_ID;
    assign adc.reg_addr     = reg_addr_q;
    assign adc.reg_addr_vld = addr_vld_q;
    assign adc.wr_data      = wr_data_q;
    assign adc.wr_data_vld  = wr_data_vld_q;

    assign sample_data = sample_data_q;
    assign sample_ch   = sample_ch_q;
    assign sample_vld  = sample_vld_q;
    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;

endmodule
